// File: rtl/mem_sched_pkg.sv
// Shared types and width helpers for the SDRAM client scheduler.
// Build option: define MEM_SCHED_STARVE_EN to enable the starvation guard in mem_sched.
// No logic lives here; only enums, defaults and constant functions.
package mem_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_AN     = 24;
  localparam int DEF_DN     = 16;
  localparam int DEF_IN     = 4;
  localparam int DEF_BURST  = 8;
  localparam int DEF_PRIO   = 0;
  localparam int DEF_TAGS   = 4;
  localparam int DEF_STARVE = 15;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy width for a FIFO of depth n (counts 0..n inclusive).
  function automatic int lvl_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mem_sched_tagq.sv
// Purpose: FIFO of client indices, one entry per outstanding read burst.
// Latency: push visible at dout/level the cycle after the edge; dout is combinational from head.
// Backpressure: none inside; caller must not push when full unless popping on the same edge.
module mem_sched_tagq
  import mem_sched_pkg::*;
#(
  parameter int DEPTH = DEF_TAGS,
  parameter int W     = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = idx_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = slots[rd_ptr];

  // Storage needs no reset: entries are only read while level says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop keep the level steady.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Purpose: shares one SDRAM controller port among IN clients (fixed-priority PRIO, round-robin rest).
// Latency: request seen in IDLE -> mem_req next cycle; ack is combinational with mem_ack; 2-cycle grant spacing.
// Backpressure: clients hold req until ack; reads stall while TAGS bursts are outstanding (writes still pass).
// Build option: MEM_SCHED_STARVE_EN adds per-client wait counters that can override PRIO.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int AN     = DEF_AN,
  parameter int DN     = DEF_DN,
  parameter int IN     = DEF_IN,
  parameter int BURST  = DEF_BURST,
  parameter int PRIO   = DEF_PRIO,
  parameter int TAGS   = DEF_TAGS,
  parameter int STARVE = DEF_STARVE
) (
  input  logic                   clkSYS,
  input  logic                   n_reset,
  input  logic [IN-1:0]          req,
  input  logic [AN-1:0]          req_addr [IN],
  input  logic [DN-1:0]          req_data [IN],
  input  logic                   req_wr   [IN],
  output logic [IN-1:0]          ack,
  output logic [IN-1:0]          valid,
  output logic                   mem_req,
  output logic [AN-1:0]          mem_addr,
  output logic [DN-1:0]          mem_data,
  output logic                   mem_wr,
  input  logic                   mem_ack,
  input  logic                   mem_valid,
  output logic [lvl_w(TAGS)-1:0] tag_level,
  output logic                   busy
);

  localparam int GW = idx_w(IN);
  localparam int BW = idx_w(BURST);
  localparam logic [GW-1:0] RR_INIT = GW'((PRIO + 1) % IN);
  localparam logic [GW-1:0] PRIO_IX = GW'(PRIO);

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] gnt;
  logic [GW-1:0] rr;
  logic [GW-1:0] win;
  logic [IN-1:0] elig;
  logic [BW-1:0] beat;
  logic          tq_push;
  logic          tq_pop;
  logic          tq_full;
  logic          tq_empty;
  logic [GW-1:0] tq_head;
  logic          grant_now;
  logic          done_now;

  // First set bit of mask at or after start, wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [IN-1:0] mask, input logic [GW-1:0] start);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < IN; k++) begin
      idx = (int'(start) + k) % IN;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
    return pick;
  endfunction

  assign grant_now = (state == IDLE) && (|elig);
  assign done_now  = (state == GRANT) && mem_ack;
  assign mem_req   = (state == GRANT);
  assign busy      = mem_req || !tq_empty;

  // A read is only worth granting if there is a tag slot for its burst.
  always_comb begin
    elig = '0;
    for (int i = 0; i < IN; i++) begin
      elig[i] = req[i] && (req_wr[i] || !tq_full);
    end
  end

`ifdef MEM_SCHED_STARVE_EN
  localparam int WAIT_W = 4;

  logic [WAIT_W-1:0] wait_cnt [IN];
  logic [IN-1:0]     starved;

  // A client is starved once it has watched STARVE grants go to PRIO.
  always_comb begin
    starved = '0;
    for (int i = 0; i < IN; i++) begin
      starved[i] = (i != PRIO) && elig[i] && (wait_cnt[i] == WAIT_W'(STARVE));
    end
  end

  // Starved clients outrank PRIO; among several, round-robin order decides.
  always_comb begin
    win = rr_pick(elig, rr);
    if (|starved)          win = rr_pick(starved, rr);
    else if (elig[PRIO])   win = PRIO_IX;
  end

  // Count PRIO grants seen by each waiting client; clear on its own ack.
  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      for (int i = 0; i < IN; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < IN; i++) begin
        if (i != PRIO) begin
          if (done_now && gnt == GW'(i))
            wait_cnt[i] <= '0;
          else if (grant_now && win == PRIO_IX && elig[i] && wait_cnt[i] != WAIT_W'(STARVE))
            wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // PRIO is strictly highest; everyone else rotates from the rr pointer.
  always_comb begin
    win = rr_pick(elig, rr);
    if (elig[PRIO]) win = PRIO_IX;
  end
`endif

  // Next state and the same-cycle ack back to the granted client.
  always_comb begin
    state_nxt = state;
    ack       = '0;
    tq_push   = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) state_nxt = GRANT;
      end
      GRANT: begin
        if (mem_ack) begin
          ack[gnt]  = 1'b1;
          tq_push   = !mem_wr;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched grant and downstream command; rr advances past non-PRIO winners.
  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      state    <= IDLE;
      gnt      <= '0;
      rr       <= RR_INIT;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_now) begin
        gnt      <= win;
        mem_addr <= req_addr[win];
        mem_data <= req_data[win];
        mem_wr   <= req_wr[win];
      end
      if (done_now && gnt != PRIO_IX) begin
        rr <= (gnt == GW'(IN - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  // Route each returned word to whoever owns the oldest outstanding burst.
  always_comb begin
    valid  = '0;
    tq_pop = 1'b0;
    if (mem_valid && !tq_empty) begin
      valid[tq_head] = 1'b1;
      tq_pop         = (beat == BW'(BURST - 1));
    end
  end

  // Beat counter within the current burst; stray words with no owner are dropped.
  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      beat <= '0;
    end else if (mem_valid && !tq_empty) begin
      beat <= (beat == BW'(BURST - 1)) ? '0 : beat + 1'b1;
    end
  end

  mem_sched_tagq #(
    .DEPTH (TAGS),
    .W     (GW)
  ) u_tagq (
    .clk     (clkSYS),
    .n_reset (n_reset),
    .push    (tq_push),
    .pop     (tq_pop),
    .din     (gnt),
    .dout    (tq_head),
    .level   (tag_level),
    .full    (tq_full),
    .empty   (tq_empty)
  );

endmodule
